segre_mem_if: RTL and testbench
===============================

SEGRE_MEM_IF -- requirements
Module: segre_mem_if

Interface
REQ-001 The module SHALL have parameter WORD_SIZE, default 32, data width in bits (taken from segre_pkg).
REQ-002 The module SHALL have parameter ADDR_SIZE, default 32, byte address width (taken from segre_pkg).
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 256, the watchdog limit in cycles (used only under REQ-029).
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The module SHALL have port rsn_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have the following core-side ports:
- addr_i, input, ADDR_SIZE: byte address from the core.
- rd_i, input, 1: read request.
- wr_i, input, 1: write request.
- data_type_i, input, memop_data_type_e: access size (BYTE, HALF or WORD).
- wr_data_i, input, WORD_SIZE: store data, right-aligned.
- rd_data_o, output, WORD_SIZE: load data, right-aligned and zero-extended.
- done_o, output, 1: one-cycle completion pulse.
- err_o, output, 1: error qualifier, valid only with done_o.
- busy_o, output, 1: transaction in flight, used by the core to stall.
REQ-007 The module SHALL have the following memory-side ports:
- req_o, output, 1: request.
- we_o, output, 1: write enable.
- maddr_o, output, ADDR_SIZE: word-aligned address, with bits [1:0]=0.
- be_o, output, 4: byte enables.
- wdata_o, output, WORD_SIZE: lane-positioned store data.
- gnt_i, input, 1: request accepted.
- rvalid_i, input, 1: read data valid.
- rdata_i, input, WORD_SIZE: read data.

Function
REQ-008 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, DONE.
REQ-009 In IDLE, when exactly one of rd_i or wr_i is 1 and the access is aligned, the block SHALL capture addr, type, wr_data and direction, then move to REQ on the next edge.
REQ-010 Alignment SHALL be defined as follows:
- BYTE is always aligned.
- HALF requires addr_i[0]=0.
- WORD requires addr_i[1:0]=0.
REQ-011 In IDLE, if the access is misaligned, or if rd_i and wr_i are both 1, the FSM SHALL go to DONE with err_o=1 and SHALL NOT assert req_o.
REQ-012 In REQ, req_o SHALL be 1, and we_o, maddr_o, be_o and wdata_o SHALL be held stable until gnt_i=1.
REQ-013 In REQ with gnt_i=1, the FSM SHALL go to DONE for a write and to WAIT for a read; req_o SHALL be 0 from the next cycle.
REQ-014 In WAIT, req_o SHALL be 0; on rvalid_i=1 the block SHALL register the extracted read data and go to DONE.
REQ-015 In DONE, done_o SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-016 busy_o SHALL be 1 in REQ and WAIT, and SHALL be 1 in IDLE whenever a request is present; it SHALL be 0 in DONE.
REQ-017 The core SHALL hold its request inputs stable until done_o; a new request SHALL be sampled no earlier than the IDLE cycle following DONE.
REQ-018 be_o SHALL be:
- BYTE: 4'b0001 << addr[1:0].
- HALF: 4'b0011 << addr[1:0].
- WORD: 4'b1111.
REQ-019 wdata_o SHALL be wr_data shifted left by 8*addr[1:0], with bits outside be_o as don't-care.
REQ-020 rd_data_o SHALL be rdata_i shifted right by 8*addr[1:0], masked to 8, 16 or 32 bits and zero-extended; sign extension is handled downstream.
REQ-021 rd_data_o SHALL hold its last value until the next read completes; writes and errors SHALL NOT change it.
REQ-022 Minimum latency SHALL be:
- Write with gnt_i in the same cycle: done_o 2 cycles after the request.
- Read with gnt_i and rvalid_i each one cycle after the previous state: done_o 3 cycles after the request.
REQ-023 rvalid_i or gnt_i arriving in a state that does not expect them SHALL be ignored.

Reset
REQ-024 While rsn_i=0, the FSM SHALL be in IDLE and all outputs SHALL be 0 (including rd_data_o, done_o, err_o, busy_o, req_o, we_o, maddr_o, be_o, wdata_o).
REQ-025 Reset asserted mid-transaction SHALL abort immediately, with req_o=0 asynchronously and no done_o for the aborted access.
REQ-026 After rsn_i rises, a request SHALL first be sampled on the first rising edge.

Configuration
REQ-027 The macro SEGRE_MEM_IF_TIMEOUT_EN SHALL enable a watchdog counter.
REQ-028 Without SEGRE_MEM_IF_TIMEOUT_EN, no counter SHALL exist, and REQ and WAIT SHALL wait indefinitely for gnt_i or rvalid_i.
REQ-029 With SEGRE_MEM_IF_TIMEOUT_EN:
- The counter SHALL clear on entry to REQ and SHALL increment each cycle in REQ and WAIT.
- When it reaches TIMEOUT_CYCLES-1 without the awaited handshake, the FSM SHALL go to DONE with err_o=1, drop req_o, and leave rd_data_o unchanged.
- A handshake arriving in that same cycle SHALL take priority over the timeout.

Verification
REQ-030 Scenario 1, word write: addr 0x100, WORD, wr_data 0xDEADBEEF, gnt_i=1 immediately. Required response: maddr_o=0x100, be_o=1111, wdata_o=0xDEADBEEF, done_o=1 with err_o=0.
REQ-031 Scenario 2, byte read: addr 0x203, BYTE, rdata_i 0xAB112233. Required response: be_o=1000, maddr_o=0x200, rd_data_o=0x000000AB.
REQ-032 Scenario 3, half write: addr 0x302, HALF, wr_data 0x0000BEEF. Required response: be_o=1100, wdata_o[31:16]=0xBEEF.
REQ-033 Scenario 4, misaligned word read at 0x101. Required response: req_o never 1, done_o=1 with err_o=1 one cycle later, rd_data_o unchanged.
REQ-034 Scenario 5, gnt_i delayed 5 cycles. Required response: req_o, maddr_o and be_o stay stable for all 6 REQ cycles, and busy_o=1 throughout.
REQ-035 Scenario 6, reset asserted during WAIT, with rvalid_i arriving later. Required response: req_o=0 and done_o=0, the FSM is in IDLE, and with SEGRE_MEM_IF_TIMEOUT_EN and no gnt_i, err_o=1 after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/segre_mem_if_if.sv
// Shared types plus the core-side and memory-side buses of segre_mem_if.
// Holds segre_pkg so the interfaces and the design see one type definition.
package segre_pkg;
  localparam int WORD_SIZE = 32;
  localparam int ADDR_SIZE = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;
endpackage

interface segre_core_bus #(
  parameter int WORD_SIZE = segre_pkg::WORD_SIZE,
  parameter int ADDR_SIZE = segre_pkg::ADDR_SIZE
);
  logic [ADDR_SIZE-1:0]        addr_i;
  logic                        rd_i;
  logic                        wr_i;
  segre_pkg::memop_data_type_e data_type_i;
  logic [WORD_SIZE-1:0]        wr_data_i;
  logic [WORD_SIZE-1:0]        rd_data_o;
  logic                        done_o;
  logic                        err_o;
  logic                        busy_o;

  modport master (
    output addr_i, rd_i, wr_i, data_type_i, wr_data_i,
    input  rd_data_o, done_o, err_o, busy_o
  );
  modport slave (
    input  addr_i, rd_i, wr_i, data_type_i, wr_data_i,
    output rd_data_o, done_o, err_o, busy_o
  );
endinterface

interface segre_mem_bus #(
  parameter int WORD_SIZE = segre_pkg::WORD_SIZE,
  parameter int ADDR_SIZE = segre_pkg::ADDR_SIZE
);
  logic                 req_o;
  logic                 we_o;
  logic [ADDR_SIZE-1:0] maddr_o;
  logic [3:0]           be_o;
  logic [WORD_SIZE-1:0] wdata_o;
  logic                 gnt_i;
  logic                 rvalid_i;
  logic [WORD_SIZE-1:0] rdata_i;

  modport master (
    output req_o, we_o, maddr_o, be_o, wdata_o,
    input  gnt_i, rvalid_i, rdata_i
  );
  modport slave (
    input  req_o, we_o, maddr_o, be_o, wdata_o,
    output gnt_i, rvalid_i, rdata_i
  );
endinterface

// File: rtl/segre_mem_if.sv
// Core-to-memory adapter: aligns byte/half/word accesses onto a word bus with a req/gnt/rvalid handshake.
// Optional watchdog enabled by defining SEGRE_MEM_IF_TIMEOUT_EN.
module segre_mem_if
  import segre_pkg::*;
#(
  parameter int WORD_SIZE      = segre_pkg::WORD_SIZE,
  parameter int ADDR_SIZE      = segre_pkg::ADDR_SIZE,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk_i,
  input  logic          rsn_i,
  segre_core_bus.slave  core,
  segre_mem_bus.master  mem
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e                 state_reg, state_next;
  logic                   we_reg;
  logic [ADDR_SIZE-1:0]   maddr_reg;
  logic [3:0]             be_reg;
  logic [WORD_SIZE-1:0]   wdata_reg;
  memop_data_type_e       type_reg;
  logic [1:0]             off_reg;
  logic                   err_reg, err_next;
  logic [WORD_SIZE-1:0]   rd_data_reg, rd_data_next;

  logic                   capture;
  logic                   rd_load;
  logic                   timeout_hit;
  logic [1:0]             off;
  logic                   aligned;
  logic                   req_present;
  logic                   req_ok;
  logic [3:0]             be_lane;
  logic [WORD_SIZE-1:0]   wdata_lane;
  logic [WORD_SIZE-1:0]   rd_shift;
  logic [WORD_SIZE-1:0]   rd_mask;

  assign off         = core.addr_i[1:0];
  assign req_present = core.rd_i | core.wr_i;
  assign req_ok      = (core.rd_i ^ core.wr_i) & aligned;

  always_comb begin
    aligned = 1'b0;
    be_lane = 4'b0000;
    case (core.data_type_i)
      BYTE: begin
        aligned = 1'b1;
        be_lane = 4'b0001 << off;
      end
      HALF: begin
        aligned = ~off[0];
        be_lane = 4'b0011 << off;
      end
      WORD: begin
        aligned = (off == 2'b00);
        be_lane = 4'b1111;
      end
      default: begin
        aligned = 1'b0;
        be_lane = 4'b0000;
      end
    endcase
  end

  assign wdata_lane = core.wr_data_i << {off, 3'b000};

  // Load path: bring the addressed lane down to bit 0, then keep only the access width.
  assign rd_shift = mem.rdata_i >> {off_reg, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < WORD_SIZE / 8; gi++) begin : g_rd_lane
      assign rd_mask[gi*8 +: 8] = {8{(gi == 0) ||
                                     ((gi == 1) && (type_reg != BYTE)) ||
                                     (type_reg == WORD)}};
    end
  endgenerate

  assign rd_data_next = rd_shift & rd_mask;

`ifdef SEGRE_MEM_IF_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_reg;

  // One budget covers the whole transaction: REQ and WAIT share the same count.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      cnt_reg <= '0;
    end else if (capture) begin
      cnt_reg <= '0;
    end else if ((state_reg == REQ) || (state_reg == WAIT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = ((state_reg == REQ) || (state_reg == WAIT)) &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    capture    = 1'b0;
    rd_load    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_present) begin
          if (req_ok) begin
            state_next = REQ;
            capture    = 1'b1;
            err_next   = 1'b0;
          end else begin
            state_next = DONE;
            err_next   = 1'b1;
          end
        end
      end
      REQ: begin
        // A grant in the limit cycle still wins over the watchdog.
        if (mem.gnt_i) begin
          state_next = we_reg ? DONE : WAIT;
        end else if (timeout_hit) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      WAIT: begin
        if (mem.rvalid_i) begin
          state_next = DONE;
          rd_load    = 1'b1;
        end else if (timeout_hit) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_reg   <= IDLE;
      we_reg      <= 1'b0;
      maddr_reg   <= '0;
      be_reg      <= 4'b0000;
      wdata_reg   <= '0;
      type_reg    <= BYTE;
      off_reg     <= 2'b00;
      err_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (capture) begin
        we_reg    <= core.wr_i;
        maddr_reg <= {core.addr_i[ADDR_SIZE-1:2], 2'b00};
        be_reg    <= be_lane;
        wdata_reg <= wdata_lane;
        type_reg  <= core.data_type_i;
        off_reg   <= off;
      end
      if (rd_load) begin
        rd_data_reg <= rd_data_next;
      end
    end
  end

  assign mem.req_o   = (state_reg == REQ);
  assign mem.we_o    = we_reg;
  assign mem.maddr_o = maddr_reg;
  assign mem.be_o    = be_reg;
  assign mem.wdata_o = wdata_reg;

  assign core.rd_data_o = rd_data_reg;
  assign core.done_o    = (state_reg == DONE);
  assign core.err_o     = (state_reg == DONE) & err_reg;
  // Gated by reset so a request held by the core during reset does not raise busy.
  assign core.busy_o    = rsn_i & ((state_reg == REQ) || (state_reg == WAIT) ||
                                   ((state_reg == IDLE) && req_present));

endmodule

// File: tb/tb_segre_mem_if.sv
// Randomized bench for segre_mem_if against a transaction-level timing model; honours SEGRE_MEM_IF_TIMEOUT_EN.
module tb_segre_mem_if;
  import segre_pkg::*;

  localparam int TO = 16;
`ifdef SEGRE_MEM_IF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rsn = 1'b0;
  always #5 clk = ~clk;

  segre_core_bus #(.WORD_SIZE(32), .ADDR_SIZE(32)) core_bus ();
  segre_mem_bus  #(.WORD_SIZE(32), .ADDR_SIZE(32)) mem_bus ();

  segre_mem_if #(.WORD_SIZE(32), .ADDR_SIZE(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .core  (core_bus),
    .mem   (mem_bus)
  );

  // Expectations for the current cycle, written by the driver only.
  bit          run = 1'b0;
  bit          exp_rst, exp_req, exp_busy, exp_done, exp_err, exp_we;
  logic [31:0] exp_maddr, exp_wdata, model_rd;
  logic [3:0]  exp_be;
  int          pin_id = 0;
  int          pin_arg = 0;
  int          txn = 0;

  // Owned by the compare process.
  int          checks = 0;
  int          errors = 0;
  int          req_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] last_maddr = '0, last_wdata = '0;
  logic [3:0]  last_be = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic [31:0] m;
    forever begin
      @(negedge clk);
      if (run) begin
        if (mem_bus.req_o === 1'b1) begin
          req_cnt++;
          last_maddr = mem_bus.maddr_o;
          last_be    = mem_bus.be_o;
          last_wdata = mem_bus.wdata_o;
        end
        if (core_bus.done_o === 1'b1) begin
          done_cnt++;
          last_err = core_bus.err_o;
        end
        if (exp_rst) begin
          chk("rst_ctrl", 32'({mem_bus.req_o, mem_bus.we_o, core_bus.done_o,
                               core_bus.err_o, core_bus.busy_o, mem_bus.be_o}), 32'h0);
          chk("rst_maddr", mem_bus.maddr_o, 32'h0);
          chk("rst_wdata", mem_bus.wdata_o, 32'h0);
          chk("rst_rdata", core_bus.rd_data_o, 32'h0);
        end else begin
          chk("req", 32'(mem_bus.req_o), 32'(exp_req));
          chk("busy", 32'(core_bus.busy_o), 32'(exp_busy));
          chk("done", 32'(core_bus.done_o), 32'(exp_done));
          if (exp_done) chk("err", 32'(core_bus.err_o), 32'(exp_err));
          chk("rd_data", core_bus.rd_data_o, model_rd);
          if (exp_req) begin
            m = {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}};
            chk("we", 32'(mem_bus.we_o), 32'(exp_we));
            chk("maddr", mem_bus.maddr_o, exp_maddr);
            chk("be", 32'(mem_bus.be_o), 32'(exp_be));
            chk("wdata", mem_bus.wdata_o & m, exp_wdata & m);
          end
        end
        case (pin_id)
          1: begin
            chk("s1_maddr", last_maddr, 32'h0000_0100);
            chk("s1_be", 32'(last_be), 32'h0000_000F);
            chk("s1_wdata", last_wdata, 32'hDEAD_BEEF);
            chk("s1_err", 32'(last_err), 32'h0);
          end
          2: begin
            chk("s2_be", 32'(last_be), 32'h0000_0008);
            chk("s2_maddr", last_maddr, 32'h0000_0200);
            chk("s2_rdata", core_bus.rd_data_o, 32'h0000_00AB);
          end
          3: begin
            chk("s3_be", 32'(last_be), 32'h0000_000C);
            chk("s3_wdata_hi", 32'(last_wdata[31:16]), 32'h0000_BEEF);
          end
          4: begin
            chk("s4_no_req", req_cnt, pin_arg);
            chk("s4_err", 32'(last_err), 32'h1);
            chk("s4_rdata", core_bus.rd_data_o, 32'h0000_00AB);
          end
          5: chk("s5_req_cycles", req_cnt, pin_arg);
          6: begin
            chk("to_req_cycles", req_cnt, pin_arg);
            chk("to_err", 32'(last_err), 32'h1);
          end
          7: chk("rst_no_done", done_cnt, pin_arg);
          default: ;
        endcase
      end
    end
  end

  task automatic cyc(input bit rq, bz, dn, er, g, rv, input logic [31:0] rdt);
    mem_bus.gnt_i    = g;
    mem_bus.rvalid_i = rv;
    mem_bus.rdata_i  = rdt;
    exp_req  = rq;
    exp_busy = bz;
    exp_done = dn;
    exp_err  = er;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int id, input int arg);
    core_bus.rd_i = 1'b0;
    core_bus.wr_i = 1'b0;
    pin_arg = arg;
    pin_id  = id;
    cyc(0, 0, 0, 0, 1'($urandom), 1'($urandom), $urandom);
    pin_id = 0;
  endtask

  task automatic set_req(input bit rd, wr, input memop_data_type_e dt,
                         input logic [31:0] addr, wd);
    int off;
    off = int'(addr[1:0]);
    core_bus.rd_i        = rd;
    core_bus.wr_i        = wr;
    core_bus.data_type_i = dt;
    core_bus.addr_i      = addr;
    core_bus.wr_data_i   = wd;
    exp_we    = wr;
    exp_maddr = addr & 32'hFFFF_FFFC;
    exp_be    = (dt == BYTE) ? 4'(1 << off) : (dt == HALF) ? 4'(3 << off) : 4'hF;
    exp_wdata = wd << (8 * off);
  endtask

  // g: REQ cycles before the one carrying gnt; r: WAIT cycles before rvalid.
  task automatic trans(input bit rd, wr, input memop_data_type_e dt,
                       input logic [31:0] addr, wd, input int g, r,
                       input logic [31:0] rdat);
    bit ok, hs, tout;
    int n, off;
    logic [31:0] mask;
    off  = int'(addr[1:0]);
    ok   = (rd != wr) && ((dt == BYTE) || (dt == HALF && addr[0] == 1'b0) ||
                          (dt == WORD && addr[1:0] == 2'b00));
    tout = 1'b0;
    n    = 0;
    set_req(rd, wr, dt, addr, wd);
    cyc(0, 1, 0, 0, 1'($urandom), 1'($urandom), $urandom);
    if (ok) begin
      for (int i = 0; i <= g; i++) begin
        hs = (i == g);
        cyc(1, 1, 0, 0, hs, 1'($urandom), $urandom);
        n++;
        if (hs) break;
        if (TO_EN && n == TO) begin
          tout = 1'b1;
          break;
        end
      end
      if (rd && !tout) begin
        for (int j = 0; j <= r; j++) begin
          hs = (j == r);
          cyc(0, 1, 0, 0, 1'($urandom), hs, hs ? rdat : $urandom);
          n++;
          if (hs) break;
          if (TO_EN && n == TO) begin
            tout = 1'b1;
            break;
          end
        end
        if (!tout) begin
          mask = (dt == BYTE) ? 32'h0000_00FF : (dt == HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
          model_rd = (rdat >> (8 * off)) & mask;
        end
      end
    end
    cyc(0, 0, 1, !ok || tout, 1'($urandom), 1'($urandom), $urandom);
    txn++;
    $display("txn %0d rd=%0d wr=%0d type=%0d addr=%h wdata=%h gnt_dly=%0d rv_dly=%0d err=%0d rd_model=%h",
             txn, rd, wr, dt, addr, wd, g, r, !ok || tout, model_rd);
  endtask

  initial begin
    int snap, k;
    logic [31:0] a;
    memop_data_type_e dt;

    exp_rst  = 1'b1;
    model_rd = '0;
    exp_req = 0; exp_busy = 0; exp_done = 0; exp_err = 0; exp_we = 0;
    exp_maddr = '0; exp_wdata = '0; exp_be = '0;
    set_req(1, 0, WORD, 32'h0000_0040, 32'h0);
    mem_bus.gnt_i = 1'b1; mem_bus.rvalid_i = 1'b1; mem_bus.rdata_i = 32'hFFFF_FFFF;
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rsn = 1'b1;
    exp_rst = 1'b0;

    trans(0, 1, WORD, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0);
    idle(1, 0);
    trans(1, 0, BYTE, 32'h0000_0203, 32'h0, 1, 1, 32'hAB11_2233);
    idle(2, 0);
    trans(0, 1, HALF, 32'h0000_0302, 32'h0000_BEEF, 0, 0, 32'h0);
    idle(3, 0);
    snap = req_cnt;
    trans(1, 0, WORD, 32'h0000_0101, 32'h0, 0, 0, 32'h0);
    idle(4, snap);
    snap = req_cnt;
    trans(0, 1, WORD, 32'h0000_0600, 32'h1234_5678, 5, 0, 32'h0);
    idle(5, snap + 6);
    trans(1, 1, WORD, 32'h0000_0700, 32'h0, 0, 0, 32'h0);

    // Reset during WAIT with rvalid arriving while reset is held.
    snap = done_cnt;
    set_req(1, 0, WORD, 32'h0000_0400, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 1, 0, 32'h0);
    rsn = 1'b0; exp_rst = 1'b1; model_rd = '0;
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h5555_AAAA);
    cyc(0, 0, 0, 0, 1, 1, 32'h5555_AAAA);
    core_bus.rd_i = 1'b0;
    rsn = 1'b1; exp_rst = 1'b0;
    idle(7, snap);

    // Reset during REQ: req_o must drop before the next clock edge.
    set_req(0, 1, HALF, 32'h0000_0812, 32'hCAFE_0000);
    cyc(0, 1, 0, 0, 0, 0, 32'h0);
    rsn = 1'b0; exp_rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 1, 0, 32'h0);
    rsn = 1'b1; exp_rst = 1'b0;
    trans(1, 0, HALF, 32'h0000_0A02, 32'h0, 0, 0, 32'h8765_4321);

    if (TO_EN) begin
      snap = req_cnt;
      trans(1, 0, WORD, 32'h0000_0500, 32'h0, TO + 5, 0, 32'h0);
      idle(6, snap + TO);
      trans(0, 1, BYTE, 32'h0000_0501, 32'h77, TO - 1, 0, 32'h0);
      trans(1, 0, BYTE, 32'h0000_0502, 32'h0, 2, TO + 5, 32'h0);
    end

    for (int it = 0; it < 80; it++) begin
      dt = memop_data_type_e'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 9) < 7)
        a = (dt == WORD) ? (a & 32'hFFFF_FFFC) : (dt == HALF) ? (a & 32'hFFFF_FFFE) : a;
      k = $urandom_range(0, 9);
      if (k < 9)
        trans(k < 4 || k == 8, k >= 4, dt, a, $urandom,
              $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 2) == 0) idle(0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
